puf_access_arb: RTL and testbench
=================================

PUF_ACCESS_ARB -- requirements
Module: puf_access_arb

Interface
REQ-001 Parameter TimeoutCycles, default 1024: maximum cycles waiting for a core result.
REQ-002 Parameter ChallengeW, default 128: challenge width.
REQ-003 Parameter ResponseW, default 256: response width.
REQ-004 clk_i  in  1  sole clock.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 sw_req_i  in  1  software challenge-response request, level, held until sw_ack_o.
REQ-007 sw_challenge_i  in  ChallengeW  challenge, sampled at grant.
REQ-008 sw_ack_o  out  1  one-cycle completion pulse.
REQ-009 sw_response_o  out  ResponseW  response, valid while sw_ack_o is high.
REQ-010 sw_err_o  out  1  timeout flag, qualifies sw_ack_o.
REQ-011 es_req_i  in  1  entropy-source request, level, held until es_ack_o.
REQ-012 es_ack_o  out  1  one-cycle completion pulse.
REQ-013 es_rng_o  out  4  random nibble, valid while es_ack_o is high.
REQ-014 es_err_o  out  1  timeout flag, qualifies es_ack_o.
REQ-015 core_enable_o, core_mode_o (0=CR, 1=RNG), core_ready_cha_o, core_rng_req_o  out  1 each  PUF core controls.
REQ-016 core_challenge_o  out  ChallengeW  latched challenge.
REQ-017 core_response_valid_i, core_rng4bit_done_i  in  1 each  core completion strobes.
REQ-018 core_response_i  in  ResponseW and core_rng4bit_i  in  4: core results.
REQ-019 busy_o  out  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, CR_START, CR_WAIT, RNG_WAIT, RELEASE.
REQ-021 IDLE SHALL grant one pending requester per cycle, round-robin; when both request, the requester not granted last wins; the first grant after reset goes to SW.
REQ-022 An SW grant SHALL latch sw_challenge_i into core_challenge_o and enter CR_START.
REQ-023 CR_START SHALL last exactly one cycle, with core_enable_o=1, core_mode_o=0 and core_ready_cha_o=1 (single-cycle pulse), then enter CR_WAIT.
REQ-024 An ES grant SHALL enter RNG_WAIT with core_enable_o=1, core_mode_o=1 and core_rng_req_o=1 held for the whole of RNG_WAIT.
REQ-025 CR_WAIT SHALL register core_response_i on core_response_valid_i and pulse sw_ack_o the next cycle, in RELEASE.
REQ-026 RNG_WAIT SHALL register core_rng4bit_i on core_rng4bit_done_i and pulse es_ack_o the next cycle, in RELEASE.
REQ-027 A 16-bit wait counter SHALL clear on entry to CR_WAIT or RNG_WAIT and increment each wait cycle; reaching TimeoutCycles-1 without a strobe SHALL pulse the ack with its err flag set and data zero.
REQ-028 A core strobe in the same cycle as timeout SHALL win: err=0 and data captured.
REQ-029 RELEASE SHALL drive core_enable_o=0 for exactly one cycle, then return to IDLE; the earliest next grant is therefore the cycle after that.
REQ-030 Core strobes outside the matching wait state SHALL be ignored.
REQ-031 Deasserting a request after grant SHALL NOT abort the transaction; the ack is still issued.
REQ-032 sw_response_o and es_rng_o SHALL hold their last captured values between acks.
REQ-033 Latency, SW grant to sw_ack_o: 2 + N cycles, where N is the number of CR_WAIT cycles up to and including the strobe.

Reset
REQ-034 While rst_ni=0, the FSM SHALL be IDLE, all outputs 0, all data registers 0, the counter 0 and the round-robin pointer at SW.
REQ-035 Reset mid-transaction SHALL drop the transaction with no ack, and core_enable_o SHALL go low asynchronously.

Structure
REQ-036 Package puf_access_pkg SHALL hold the state enum, the CR/RNG mode constants and the default width parameters.
REQ-037 The timeout counter SHALL be sub-module puf_wait_timer, with inputs clear and enable, output expired, and parameter TimeoutCycles.

Verification
REQ-038 sw_req_i=1, challenge=0x0123..EF; core_response_valid_i 5 cycles after core_ready_cha_o -> one core_ready_cha_o pulse, sw_ack_o at grant+7, sw_response_o matches, sw_err_o=0.
REQ-039 es_req_i=1, core_rng4bit_done_i with nibble 0xA after 3 cycles -> es_rng_o=0xA with es_ack_o, core_mode_o=1 throughout.
REQ-040 Both requests held continuously -> grants alternate SW, ES, SW, ES with one RELEASE cycle between transactions.
REQ-041 TimeoutCycles=8, no strobe -> sw_ack_o with sw_err_o=1 and response 0; valid asserted exactly in the expiry cycle -> err=0.
REQ-042 rst_ni low during CR_WAIT -> outputs 0 immediately, no ack; after release a fresh SW request completes normally.

Source files
------------

// File: rtl/puf_access_pkg.sv
// Shared types and default sizes for the PUF access arbiter.
package puf_access_pkg;

  localparam int unsigned DefTimeoutCycles = 1024;
  localparam int unsigned DefChallengeW    = 128;
  localparam int unsigned DefResponseW     = 256;
  localparam int unsigned WaitCntW         = 16;
  localparam int unsigned RngW             = 4;

  localparam logic ModeCr  = 1'b0;
  localparam logic ModeRng = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CR_START,
    ST_CR_WAIT,
    ST_RNG_WAIT,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/puf_wait_timer.sv
// Wait-cycle counter; expired is high in the last permitted wait cycle.
module puf_wait_timer
  import puf_access_pkg::*;
#(
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WaitCntW-1:0] LastCount = WaitCntW'(TimeoutCycles - 1);

  logic [WaitCntW-1:0] count;

  // expired mirrors (count == LastCount) and saturates there
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= (LastCount == '0);
    end else if (enable && !expired) begin
      count   <= count + WaitCntW'(1);
      expired <= ((count + WaitCntW'(1)) == LastCount);
    end
  end

endmodule

// File: rtl/puf_access_arb.sv
// Round-robin arbiter giving software and the entropy source exclusive use of the PUF core.
module puf_access_arb
  import puf_access_pkg::*;
#(
  parameter int unsigned TimeoutCycles = DefTimeoutCycles,
  parameter int unsigned ChallengeW    = DefChallengeW,
  parameter int unsigned ResponseW     = DefResponseW
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sw_req_i,
  input  logic [ChallengeW-1:0] sw_challenge_i,
  output logic                  sw_ack_o,
  output logic [ResponseW-1:0]  sw_response_o,
  output logic                  sw_err_o,
  input  logic                  es_req_i,
  output logic                  es_ack_o,
  output logic [RngW-1:0]       es_rng_o,
  output logic                  es_err_o,
  output logic                  core_enable_o,
  output logic                  core_mode_o,
  output logic                  core_ready_cha_o,
  output logic                  core_rng_req_o,
  output logic [ChallengeW-1:0] core_challenge_o,
  input  logic                  core_response_valid_i,
  input  logic                  core_rng4bit_done_i,
  input  logic [ResponseW-1:0]  core_response_i,
  input  logic [RngW-1:0]       core_rng4bit_i,
  output logic                  busy_o
);

  state_e state;
  logic   prio_es;
  logic   timer_clear;
  logic   timer_expired;

  assign timer_clear = (state != ST_CR_WAIT) && (state != ST_RNG_WAIT);

  puf_wait_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_wait_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (timer_clear),
    .enable (!timer_clear),
    .expired(timer_expired)
  );

  // Acks, errors and the challenge strobe are single-cycle pulses, cleared every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= ST_IDLE;
      prio_es          <= 1'b0;
      sw_ack_o         <= 1'b0;
      sw_response_o    <= '0;
      sw_err_o         <= 1'b0;
      es_ack_o         <= 1'b0;
      es_rng_o         <= '0;
      es_err_o         <= 1'b0;
      core_enable_o    <= 1'b0;
      core_mode_o      <= ModeCr;
      core_ready_cha_o <= 1'b0;
      core_rng_req_o   <= 1'b0;
      core_challenge_o <= '0;
      busy_o           <= 1'b0;
    end else begin
      sw_ack_o         <= 1'b0;
      sw_err_o         <= 1'b0;
      es_ack_o         <= 1'b0;
      es_err_o         <= 1'b0;
      core_ready_cha_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (sw_req_i && (!es_req_i || !prio_es)) begin
            core_challenge_o <= sw_challenge_i;
            core_enable_o    <= 1'b1;
            core_mode_o      <= ModeCr;
            core_ready_cha_o <= 1'b1;
            busy_o           <= 1'b1;
            prio_es          <= 1'b1;
            state            <= ST_CR_START;
          end else if (es_req_i) begin
            core_enable_o  <= 1'b1;
            core_mode_o    <= ModeRng;
            core_rng_req_o <= 1'b1;
            busy_o         <= 1'b1;
            prio_es        <= 1'b0;
            state          <= ST_RNG_WAIT;
          end
        end
        ST_CR_START: state <= ST_CR_WAIT;
        ST_CR_WAIT: begin
          // a strobe coinciding with expiry still delivers data
          if (core_response_valid_i || timer_expired) begin
            sw_ack_o      <= 1'b1;
            sw_err_o      <= !core_response_valid_i;
            sw_response_o <= core_response_valid_i ? core_response_i : '0;
            core_enable_o <= 1'b0;
            state         <= ST_RELEASE;
          end
        end
        ST_RNG_WAIT: begin
          if (core_rng4bit_done_i || timer_expired) begin
            es_ack_o       <= 1'b1;
            es_err_o       <= !core_rng4bit_done_i;
            es_rng_o       <= core_rng4bit_done_i ? core_rng4bit_i : '0;
            core_enable_o  <= 1'b0;
            core_rng_req_o <= 1'b0;
            core_mode_o    <= ModeCr;
            state          <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_access_arb.sv
// Randomized bench for puf_access_arb against a transaction-level timing model.
module tb_puf_access_arb;

  localparam int T  = 8;
  localparam int CW = 128;
  localparam int RW = 256;
  localparam logic [CW-1:0] FixedChal = 128'h0123456789ABCDEF0123456789ABCDEF;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          sw_req_i = 1'b0;
  logic [CW-1:0] sw_challenge_i = '0;
  logic          sw_ack_o;
  logic [RW-1:0] sw_response_o;
  logic          sw_err_o;
  logic          es_req_i = 1'b0;
  logic          es_ack_o;
  logic [3:0]    es_rng_o;
  logic          es_err_o;
  logic          core_enable_o, core_mode_o, core_ready_cha_o, core_rng_req_o;
  logic [CW-1:0] core_challenge_o;
  logic          core_response_valid_i = 1'b0;
  logic          core_rng4bit_done_i = 1'b0;
  logic [RW-1:0] core_response_i = '0;
  logic [3:0]    core_rng4bit_i = '0;
  logic          busy_o;

  puf_access_arb #(.TimeoutCycles(T), .ChallengeW(CW), .ResponseW(RW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .sw_req_i(sw_req_i), .sw_challenge_i(sw_challenge_i), .sw_ack_o(sw_ack_o),
    .sw_response_o(sw_response_o), .sw_err_o(sw_err_o),
    .es_req_i(es_req_i), .es_ack_o(es_ack_o), .es_rng_o(es_rng_o), .es_err_o(es_err_o),
    .core_enable_o(core_enable_o), .core_mode_o(core_mode_o),
    .core_ready_cha_o(core_ready_cha_o), .core_rng_req_o(core_rng_req_o),
    .core_challenge_o(core_challenge_o),
    .core_response_valid_i(core_response_valid_i), .core_rng4bit_done_i(core_rng4bit_done_i),
    .core_response_i(core_response_i), .core_rng4bit_i(core_rng4bit_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // transaction model: grant cycle, strobe wait index and resulting ack cycle
  int            k;
  bit            m_active, m_sw, m_err, last_es, sw_pend, es_pend, gen_on, fixed_chal;
  int            m_g, m_ack, m_free, m_d, force_d;
  logic [RW-1:0] m_data, last_resp;
  logic [3:0]    last_rng;
  logic [CW-1:0] m_chal;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rand_resp();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    k = 0; m_active = 0; m_free = 0; last_es = 1; sw_pend = 0; es_pend = 0;
    last_resp = '0; last_rng = '0; m_chal = '0; force_d = -1;
    sw_req_i = 0; es_req_i = 0; core_response_valid_i = 0; core_rng4bit_done_i = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 256'(busy_o), 256'(0));
    check_eq({tag, "_en"}, 256'(core_enable_o), 256'(0));
    check_eq({tag, "_sw_ack"}, 256'(sw_ack_o), 256'(0));
    check_eq({tag, "_es_ack"}, 256'(es_ack_o), 256'(0));
    check_eq({tag, "_errs"}, 256'({sw_err_o, es_err_o}), 256'(0));
    check_eq({tag, "_core_ctl"}, 256'({core_mode_o, core_ready_cha_o, core_rng_req_o}), 256'(0));
    check_eq({tag, "_resp"}, 256'(sw_response_o), 256'(0));
    check_eq({tag, "_rng"}, 256'(es_rng_o), 256'(0));
    check_eq({tag, "_chal"}, 256'(core_challenge_o), 256'(0));
  endtask

  task automatic step();
    bit exp_en, ack_sw, ack_es, win_sw, win_es;
    int w, r;
    @(negedge clk);
    if (m_active && k > m_ack) m_active = 0;
    exp_en = m_active && k > m_g && k < m_ack;
    ack_sw = m_active && m_sw && k == m_ack;
    ack_es = m_active && !m_sw && k == m_ack;
    check_eq("busy", 256'(busy_o), 256'(m_active && k > m_g));
    check_eq("core_enable", 256'(core_enable_o), 256'(exp_en));
    check_eq("ready_cha", 256'(core_ready_cha_o), 256'(m_active && m_sw && k == m_g + 1));
    check_eq("rng_req", 256'(core_rng_req_o), 256'(exp_en && !m_sw));
    if (exp_en) check_eq("core_mode", 256'(core_mode_o), 256'(!m_sw));
    check_eq("sw_ack", 256'(sw_ack_o), 256'(ack_sw));
    check_eq("es_ack", 256'(es_ack_o), 256'(ack_es));
    check_eq("sw_err", 256'(sw_err_o), 256'(ack_sw && m_err));
    check_eq("es_err", 256'(es_err_o), 256'(ack_es && m_err));
    if (ack_sw) begin last_resp = m_data; sw_pend = 0; end
    if (ack_es) begin last_rng = m_data[3:0]; es_pend = 0; end
    check_eq("sw_response", 256'(sw_response_o), 256'(last_resp));
    check_eq("es_rng", 256'(es_rng_o), 256'(last_rng));
    check_eq("core_challenge", 256'(core_challenge_o), 256'(m_chal));

    // requests: raise when idle for that requester, sometimes withdraw one already granted
    if (gen_on && m_active && k > m_g && k < m_ack && $urandom_range(0, 7) == 0) begin
      if (m_sw) sw_pend = 0; else es_pend = 0;
    end
    if (gen_on && !sw_pend && !(m_active && m_sw) && $urandom_range(0, 2) == 0) sw_pend = 1;
    if (gen_on && !es_pend && !(m_active && !m_sw) && $urandom_range(0, 2) == 0) es_pend = 1;
    sw_challenge_i = fixed_chal ? FixedChal : CW'(rand_resp());

    if (!m_active && k >= m_free && (sw_pend || es_pend)) begin
      m_sw = sw_pend && (!es_pend || last_es);
      last_es = !m_sw;
      m_g = k;
      m_active = 1;
      r = $urandom_range(0, 9);
      if (force_d >= 0) m_d = force_d;
      else if (r < 2) m_d = T + 1 + $urandom_range(0, 3);
      else if (r < 3) m_d = T;
      else m_d = $urandom_range(1, T - 1);
      force_d = -1;
      m_err = m_d > T;
      m_data = m_err ? '0 : (m_sw ? rand_resp() : RW'($urandom_range(0, 15)));
      m_ack = k + (m_sw ? 2 : 1) + (m_err ? T : m_d);
      m_free = m_ack + 1;
      if (m_sw) m_chal = sw_challenge_i;
    end
    sw_req_i = sw_pend;
    es_req_i = es_pend;

    // core strobes: exact within the matching wait window, random noise elsewhere
    core_response_i = rand_resp();
    core_rng4bit_i = 4'($urandom);
    win_sw = m_active && m_sw && k >= m_g + 2 && k < m_ack;
    win_es = m_active && !m_sw && k >= m_g + 1 && k < m_ack;
    if (win_sw) begin
      w = k - m_g - 1;
      core_response_valid_i = (w == m_d);
      if (w == m_d) core_response_i = m_data;
    end else core_response_valid_i = ($urandom_range(0, 3) == 0);
    if (win_es) begin
      w = k - m_g;
      core_rng4bit_done_i = (w == m_d);
      if (w == m_d) core_rng4bit_i = m_data[3:0];
    end else core_rng4bit_done_i = ($urandom_range(0, 3) == 0);
    k++;
  endtask

  task automatic directed(input bit is_sw, input int d, input string tag);
    bit done;
    int i;
    gen_on = 0;
    done = 0;
    i = 0;
    while (i < 60 && (m_active || k < m_free)) begin step(); i++; end
    if (is_sw) sw_pend = 1; else es_pend = 1;
    force_d = d;
    step();
    while (i < 60 && !done) begin
      step();
      i++;
      done = !m_active;
    end
    check_eq({tag, "_completed"}, 256'(done), 256'(1));
  endtask

  initial begin
    bit seen_en;
    int i;
    gen_on = 0;
    fixed_chal = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_ni = 1;

    fixed_chal = 1;
    directed(1, 5, "cr_basic");
    fixed_chal = 0;
    directed(0, 3, "rng_basic");
    directed(1, T, "cr_strobe_at_expiry");
    directed(0, T, "rng_strobe_at_expiry");
    directed(1, T + 4, "cr_timeout");
    directed(0, T + 4, "rng_timeout");

    gen_on = 1;
    repeat (1500) step();

    // reset in the middle of a challenge-response wait
    directed(1, 1, "pre_abort");
    sw_pend = 1;
    force_d = T + 10;
    i = 0;
    seen_en = 0;
    while (i < 60 && !(m_active && m_sw && k == m_g + 4)) begin step(); i++; end
    #1;
    seen_en = core_enable_o;
    check_eq("abort_reached_wait", 256'(seen_en), 256'(1));
    rst_ni = 0;
    #1;
    check_all_zero("async_reset");
    repeat (3) begin
      @(negedge clk);
      check_eq("no_ack_in_reset", 256'({sw_ack_o, es_ack_o}), 256'(0));
    end
    model_reset();
    rst_ni = 1;
    directed(1, 4, "post_reset_cr");
    gen_on = 1;
    repeat (400) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
